// File: rtl/vid_chan_swizzle.sv
// vid_chan_swizzle: registered any-to-any colour channel router with frame-synchronous map updates
// Ports: clk, rst_n (async active-low); vid_pData/VDE/HSync/VSync _in -> _out delayed by 2 cycles;
// sel/sel_load capture a source-select map into a pending register, sel_pending flags it until the
// next VSync rising edge commits it. Define VID_CHAN_SWIZZLE_INVERT_EN to add per-channel inversion (inv).
module vid_chan_swizzle #(
  parameter int CH_W  = 8,
  parameter int N_CH  = 3,
  parameter int SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH*CH_W-1:0] vid_pData_in,
  input  logic                 vid_pVDE_in,
  input  logic                 vid_pHSync_in,
  input  logic                 vid_pVSync_in,
  input  logic [N_CH*SEL_W-1:0] sel,
`ifdef VID_CHAN_SWIZZLE_INVERT_EN
  input  logic [N_CH-1:0]      inv,
`endif
  input  logic                 sel_load,
  output logic                 sel_pending,
  output logic [N_CH*CH_W-1:0] vid_pData_out,
  output logic                 vid_pVDE_out,
  output logic                 vid_pHSync_out,
  output logic                 vid_pVSync_out
);
  function automatic logic [N_CH*SEL_W-1:0] ident_map();
    logic [N_CH*SEL_W-1:0] m;
    m = '0;
    for (int i = 0; i < N_CH; i++) m[i*SEL_W +: SEL_W] = SEL_W'(i);
    return m;
  endfunction
  localparam logic [N_CH*SEL_W-1:0] IDENT = ident_map();
  logic [N_CH*CH_W-1:0]  d1, mux_d;
  logic                  vde1, hs1, vs1, vs_hist;
  logic [N_CH*SEL_W-1:0] pend_sel, act_sel;
  logic                  boundary;
`ifdef VID_CHAN_SWIZZLE_INVERT_EN
  logic [N_CH-1:0]       pend_inv, act_inv;
`endif
  assign boundary = vid_pVSync_in & ~vs_hist;
  // Unmatched (out-of-range) source indices leave the channel at zero.
  always_comb begin
    mux_d = '0;
    for (int i = 0; i < N_CH; i++)
      for (int j = 0; j < N_CH; j++)
        if (act_sel[i*SEL_W +: SEL_W] == SEL_W'(j)) mux_d[i*CH_W +: CH_W] = d1[j*CH_W +: CH_W];
`ifdef VID_CHAN_SWIZZLE_INVERT_EN
    for (int i = 0; i < N_CH; i++)
      if (act_inv[i]) mux_d[i*CH_W +: CH_W] = ~mux_d[i*CH_W +: CH_W];
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1             <= '0;
      vde1           <= 1'b0;
      hs1            <= 1'b0;
      vs1            <= 1'b0;
      vid_pData_out  <= '0;
      vid_pVDE_out   <= 1'b0;
      vid_pHSync_out <= 1'b0;
      vid_pVSync_out <= 1'b0;
    end else begin
      d1             <= vid_pData_in;
      vde1           <= vid_pVDE_in;
      hs1            <= vid_pHSync_in;
      vs1            <= vid_pVSync_in;
      vid_pData_out  <= mux_d;
      vid_pVDE_out   <= vde1;
      vid_pHSync_out <= hs1;
      vid_pVSync_out <= vs1;
    end
  end
  // The active map switches on the edge cycle itself, so the edge pixel (entering stage 1 now)
  // is the first one muxed with the new map one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_hist     <= 1'b0;
      sel_pending <= 1'b0;
      pend_sel    <= '0;
      act_sel     <= IDENT;
`ifdef VID_CHAN_SWIZZLE_INVERT_EN
      pend_inv    <= '0;
      act_inv     <= '0;
`endif
    end else begin
      vs_hist <= vid_pVSync_in;
      if (boundary && sel_pending) begin
        act_sel <= pend_sel;
`ifdef VID_CHAN_SWIZZLE_INVERT_EN
        act_inv <= pend_inv;
`endif
      end
      if (sel_load) begin
        pend_sel <= sel;
`ifdef VID_CHAN_SWIZZLE_INVERT_EN
        pend_inv <= inv;
`endif
      end
      sel_pending <= sel_load ? 1'b1 : boundary ? 1'b0 : sel_pending;
    end
  end
endmodule
